tlul_uart_host_bridge: RTL
==========================

Name: tlul_uart_host_bridge

Overview:
- TL-UL initiator driven by a byte-stream command channel, normally the RX/TX byte ports of a UART PHY.
- A host PC issues single-beat reads and writes to any TL-UL responder, including tlul_uart itself, through a short binary command protocol.
- It is the host-side counterpart to tlul_master_echo: it originates A-channel requests from external bytes and serialises D-channel responses back out as bytes.

Parameters:
- W, 4, data bus width in bytes (power of two, 1..8).
- A, 32, address width (A <= 32).
- Z, 4, a_size/d_size width.
- O, 5, source id width.
- I, 5, sink id width.
- SOURCE_ID, 0, constant a_source value.
- TIMEOUT_CYCLES, 100000, idle cycles mid-command before abort (>= 2).

Ports:
- CLK  input  1  clock; all logic rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- rx_data  input  8  command byte from UART receiver.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  bridge accepts rx_data this cycle.
- tx_data  output  8  response byte to UART transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts tx_data.
- a_opcode/a_param/a_size/a_source/a_address/a_mask/a_data/a_valid  output  3/3/Z/O/A/W/8W/1  TL-UL A channel.
- a_ready  input  1  TL-UL A channel ready.
- d_opcode/d_param/d_size/d_source/d_sink/d_data/d_error/d_valid  input  3/2/Z/O/I/8W/1/1  TL-UL D channel.
- d_ready  output  1  TL-UL D channel ready.

Behaviour:
- Reset: rx_ready=1, tx_valid=0, tx_data=0, a_valid=0, d_ready=0. All A-channel fields and internal registers are 0. FSM is IDLE; the timeout counter is 0.
- Byte transfer on rx_valid&rx_ready; tx transfer on tx_valid&tx_ready. tx_data and tx_valid are held stable until accepted.
- Command bytes: 0x52 = read, 0x57 = write.
- After the command byte come 4 address bytes, MSB first. Bits above A-1 are discarded.
- A write then carries W data bytes, LSB (byte lane 0) first.
- FSM states:
  - IDLE: rx_ready=1. 0x52 goes to ADDR with is_write=0; 0x57 goes to ADDR with is_write=1; any other byte goes to NAK.
  - ADDR: rx_ready=1. Four bytes are shifted in. After the 4th, a read goes to A_REQ and a write goes to DATA.
  - DATA: rx_ready=1. W bytes are collected. After the last one, go to A_REQ.
  - A_REQ: rx_ready=0, a_valid=1.
    - Read: a_opcode=4 (Get), a_data=0.
    - Write: a_opcode=0 (PutFullData), a_data = collected bytes.
    - Both: a_param=0, a_size=$clog2(W), a_mask=all ones, a_source=SOURCE_ID.
    - Fields are stable while a_valid=1. On a_valid&a_ready, go to D_WAIT with a_valid=0 the next cycle.
  - D_WAIT: d_ready=1. On d_valid, capture d_data and compute status:
    - 0x01 if d_error=1;
    - else 0x02 if d_opcode is not the expected value (1 AccessAckData for read, 0 AccessAck for write);
    - else 0x00.
    - Then go to RESP_STATUS. d_ready deasserts the cycle after capture.
  - RESP_STATUS: tx_data=status. On accept, a successful read goes to RESP_DATA; everything else goes to IDLE.
  - RESP_DATA: sends captured d_data as W bytes, LSB first, then goes to IDLE. Read data is sent only when status=0x00.
  - NAK: tx_data=0x3F. On accept, go to IDLE.
- Only one transaction is outstanding at a time. rx_ready=0 in A_REQ, D_WAIT, RESP_*, and NAK; upstream holds its bytes.
- Timeout:
  - In ADDR or DATA the counter increments each cycle without an accepted byte and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE with no response and the partial command is discarded.
  - The counter is inactive in all other states.
- Latency:
  - a_valid rises the cycle after the final command byte is accepted.
  - The first tx_valid rises the cycle after d_valid is sampled with d_ready.
- d_valid outside D_WAIT is ignored; d_ready=0 there.
- Reset asserted mid-transaction: immediate return to reset values, and any in-flight TL-UL request is abandoned. The system resets both ends together.

Test Plan:
- Write: bytes 57 00 00 00 7F EF BE AD DE, a_ready=1 -> one A beat with opcode 0, address 0x7F, data 0xDEADBEEF, mask 0xF, size 2. Respond d_opcode=0 -> tx byte 00.
- Read: bytes 52 00 00 00 7F, then d_opcode=1, d_data=0x12345678 -> tx bytes 00 78 56 34 12. No A beat carries opcode other than 4.
- Backpressure: a_ready low for 10 cycles -> a_valid and all A fields held stable, rx_ready=0. With tx_ready toggling every other cycle, each tx byte is sent exactly once, in order.
- Errors: d_error=1 on a read -> only tx 01, no data bytes. d_opcode=0 on a read -> tx 02. Command byte 0x41 -> tx 3F, next byte is parsed as a new command.
- Timeout: TIMEOUT_CYCLES=16, send 52 00 then stall 16 cycles -> FSM back to IDLE, no A beat, no tx. A following full 52 00 00 00 7F completes normally.
- Reset during D_WAIT: RST_N low for 1 cycle -> d_ready=0, tx_valid=0, a_valid=0, rx_ready=1 immediately. A new command is served afterwards.

Source files
------------

// File: rtl/tlul_uart_host_bridge.sv
// Byte-stream command bridge: turns host read/write commands arriving on a UART
// byte channel into single-beat TL-UL requests and serialises the responses back.
module tlul_uart_host_bridge #(
    parameter int W              = 4,
    parameter int A              = 32,
    parameter int Z              = 4,
    parameter int O              = 5,
    parameter int I              = 5,
    parameter int SOURCE_ID      = 0,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [2:0]     a_opcode,
    output logic [2:0]     a_param,
    output logic [Z-1:0]   a_size,
    output logic [O-1:0]   a_source,
    output logic [A-1:0]   a_address,
    output logic [W-1:0]   a_mask,
    output logic [8*W-1:0] a_data,
    output logic           a_valid,
    input  logic           a_ready,
    input  logic [2:0]     d_opcode,
    input  logic [1:0]     d_param,
    input  logic [Z-1:0]   d_size,
    input  logic [O-1:0]   d_source,
    input  logic [I-1:0]   d_sink,
    input  logic [8*W-1:0] d_data,
    input  logic           d_error,
    input  logic           d_valid,
    output logic           d_ready
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int DW = 8 * W;

    localparam logic [7:0] CMD_READ   = 8'h52;
    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_ERROR   = 8'h01;
    localparam logic [7:0] ST_OPCODE  = 8'h02;
    localparam logic [7:0] NAK_BYTE   = 8'h3F;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_A_REQ,
        S_D_WAIT,
        S_RESP_STATUS,
        S_RESP_DATA,
        S_NAK
    } state_t;

    state_t          state_q, state_d;
    logic            is_write_q;
    logic [31:0]     addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic [7:0]      status_q;
    logic [2:0]      byte_cnt_q;
    logic [TW-1:0]   tmo_q;

    logic            rx_fire;
    logic            tmo_hit;
    logic            addr_last;
    logic            data_last;
    logic [7:0]      d_status;

    // D-channel fields the bridge does not interpret.
    logic unused_d;
    assign unused_d = ^{d_param, d_size, d_source, d_sink};

    assign rx_fire   = rx_valid & rx_ready;
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign addr_last = (byte_cnt_q == 3'd3);
    assign data_last = (byte_cnt_q == 3'(W - 1));

    always_comb begin
        if (d_error)
            d_status = ST_ERROR;
        else if (d_opcode != (is_write_q ? OP_ACK : OP_ACK_DATA))
            d_status = ST_OPCODE;
        else
            d_status = ST_OK;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = '0;
        a_source  = '0;
        a_address = '0;
        a_mask    = '0;
        a_data    = '0;
        d_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid)
                    state_d = (rx_data == CMD_READ || rx_data == CMD_WRITE) ? S_ADDR : S_NAK;
            end
            S_ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (addr_last)
                        state_d = is_write_q ? S_DATA : S_A_REQ;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (data_last)
                        state_d = S_A_REQ;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_A_REQ: begin
                a_valid   = 1'b1;
                a_opcode  = is_write_q ? OP_PUT_FULL : OP_GET;
                a_size    = Z'($clog2(W));
                a_source  = O'(SOURCE_ID);
                a_address = addr_q[A-1:0];
                a_mask    = '1;
                a_data    = is_write_q ? wdata_q : '0;
                if (a_ready)
                    state_d = S_D_WAIT;
            end
            S_D_WAIT: begin
                d_ready = 1'b1;
                if (d_valid)
                    state_d = S_RESP_STATUS;
            end
            S_RESP_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = status_q;
                if (tx_ready)
                    state_d = (status_q == ST_OK && !is_write_q) ? S_RESP_DATA : S_IDLE;
            end
            S_RESP_DATA: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[{byte_cnt_q, 3'b000} +: 8];
                if (tx_ready && data_last)
                    state_d = S_IDLE;
            end
            S_NAK: begin
                tx_valid = 1'b1;
                tx_data  = NAK_BYTE;
                if (tx_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= 8'h00;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (rx_fire) begin
                        is_write_q <= (rx_data == CMD_WRITE);
                        byte_cnt_q <= '0;
                        tmo_q      <= '0;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr_q     <= {addr_q[23:0], rx_data};
                        byte_cnt_q <= addr_last ? 3'd0 : byte_cnt_q + 3'd1;
                        tmo_q      <= '0;
                    end else begin
                        tmo_q <= tmo_hit ? '0 : tmo_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        wdata_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
                        byte_cnt_q <= data_last ? 3'd0 : byte_cnt_q + 3'd1;
                        tmo_q      <= '0;
                    end else begin
                        tmo_q <= tmo_hit ? '0 : tmo_q + 1'b1;
                    end
                end
                S_D_WAIT: begin
                    if (d_valid) begin
                        rdata_q    <= d_data;
                        status_q   <= d_status;
                        byte_cnt_q <= '0;
                    end
                end
                S_RESP_DATA: begin
                    if (tx_ready)
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
